// File: rtl/crc16_frame_ctrl.sv
// crc16_frame_ctrl
//   Frames a byte stream for an external CRC-16 engine. Payload bytes pass
//   straight through to the output stream while the engine accumulates them.
//   After the final byte, the controller waits one settle cycle and then
//   appends the two CRC bytes, high byte first. A frame that reaches MAX_LEN
//   bytes without s_last is closed early and len_err pulses for one cycle.
//
//   Optional build macro: CRC16_FRAME_CNT_EN
//     When defined, the block adds frame_cnt (completed frames, wraps) and
//     err_cnt (truncations, saturates at 0xFF).
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   payload input stream
//   m_valid/m_ready/m_data/m_last   output stream (payload, then CRC hi, CRC lo)
//   crc_clear/crc_enable/crc_data   engine control (clear to 0xFFFF, update, data)
//   crc_value             engine result
//   busy                  high whenever the controller is not idle
//   len_err               one-cycle pulse when a frame is truncated at MAX_LEN
//   frame_cnt, err_cnt    only with CRC16_FRAME_CNT_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for s_valid; both streams stalled
// CLEAR   | one cycle: engine loads 0xFFFF, byte counter cleared
// DATA    | payload passes through; each handshake updates the engine
// SETTLE  | one cycle gap so crc_value reflects the last byte
// CRC_HI  | emit crc_value[15:8], wait for m_ready
// CRC_LO  | emit crc_value[7:0] with m_last, wait for m_ready

module crc16_frame_ctrl #(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        crc_clear,
  output logic        crc_enable,
  output logic [7:0]  crc_data,
  input  logic [15:0] crc_value,
  output logic        busy,
  output logic        len_err
`ifdef CRC16_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CRC_HI = 3'd4;
  localparam logic [2:0] ST_CRC_LO = 3'd5;

  // byte_cnt holds the number of bytes already accepted, so the byte being
  // accepted is the last allowed one when the count equals MAX_LEN-1.
  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] byte_cnt;
  logic        accept;
  logic        at_max;
  logic        trunc;

  // In DATA s_ready mirrors m_ready, so an input handshake is also an output one.
  assign accept = (state == ST_DATA) && s_valid && m_ready;
  assign at_max = (byte_cnt == LAST_IDX);
  assign trunc  = accept && !s_last && at_max;
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_last     = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    crc_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (s_valid) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        crc_clear = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
        if (accept) begin
          crc_enable = 1'b1;
          crc_data   = s_data;
          if (s_last || at_max) state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        state_nxt = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        m_valid = 1'b1;
        m_data  = crc_value[15:8];
        if (m_ready) state_nxt = ST_CRC_LO;
      end
      ST_CRC_LO: begin
        m_valid = 1'b1;
        m_data  = crc_value[7:0];
        m_last  = 1'b1;
        if (m_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_cnt <= 16'h0000;
      len_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_err <= trunc;
      if (state == ST_CLEAR) begin
        byte_cnt <= 16'h0000;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
    end
  end

`ifdef CRC16_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'h0000;
      err_cnt   <= 8'h00;
    end else begin
      if ((state == ST_CRC_LO) && m_ready) frame_cnt <= frame_cnt + 16'd1;
      if (trunc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
